// File: rtl/mem_stage.sv
// mem_stage: EX->MEM pipeline register and load-return unit.
// Captures one ALU result per instruction and hands it to writeback.
// Loads issued to the dcache park in WAIT until read data arrives. The
// returned word is then aligned and sign/zero-extended.
// A flushed load parks in DRAIN until its response has been consumed.
// Optional feature macro: MEM_TIMEOUT_EN. When it is defined, a bounded
// wait forces completion after TIMEOUT_CYCLES and sets wb_err_o.
module mem_stage #(
    parameter int         TIMEOUT_CYCLES = 256,
    parameter logic [7:0] ALU_LDB        = 8'h20,
    parameter logic [7:0] ALU_LDBU       = 8'h21,
    parameter logic [7:0] ALU_LDH        = 8'h22,
    parameter logic [7:0] ALU_LDHU       = 8'h23,
    parameter logic [7:0] ALU_LDW        = 8'h24,
    parameter logic [7:0] ALU_LLW        = 8'h25
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        pause_i,
    input  logic        ex_valid_i,
    input  logic [31:0] ex_pc_i,
    input  logic [7:0]  ex_aluop_i,
    input  logic [31:0] ex_addr_i,
    input  logic        ex_mem_req_i,
    input  logic        ex_reg_we_i,
    input  logic [4:0]  ex_reg_waddr_i,
    input  logic [31:0] ex_reg_wdata_i,
    input  logic        dc_rvalid_i,
    input  logic [31:0] dc_rdata_i,
    output logic        pause_mem_o,
    output logic        wb_valid_o,
    output logic [31:0] wb_pc_o,
    output logic        wb_reg_we_o,
    output logic [4:0]  wb_reg_waddr_o,
    output logic [31:0] wb_reg_wdata_o,
    output logic        wb_err_o
);

    typedef enum logic [1:0] {IDLE, WAIT, DRAIN} state_t;

    state_t      state_reg;
    logic        wb_valid_reg;
    logic [31:0] wb_pc_reg;
    logic        wb_reg_we_reg;
    logic [4:0]  wb_reg_waddr_reg;
    logic [31:0] wb_reg_wdata_reg;
    logic        wb_err_reg;
    logic [7:0]  ld_op_reg;
    logic [1:0]  ld_off_reg;
    logic        ld_we_reg;
    logic        resp_pend_reg;
    logic [31:0] resp_data_reg;

    logic        ex_is_load;
    logic        have_resp;
    logic [31:0] resp_word;
    logic [7:0]  byte_lane [4];
    logic [7:0]  sel_byte;
    logic [15:0] sel_half;
    logic [31:0] load_data;
    logic        timeout_hit;

    // Only the byte offset of the address matters for alignment.
    logic unused_addr_bits;
    assign unused_addr_bits = &{1'b0, ex_addr_i[31:2]};

    assign ex_is_load = (ex_aluop_i == ALU_LDB)  || (ex_aluop_i == ALU_LDBU) ||
                        (ex_aluop_i == ALU_LDH)  || (ex_aluop_i == ALU_LDHU) ||
                        (ex_aluop_i == ALU_LDW)  || (ex_aluop_i == ALU_LLW);

    // A response latched while paused is used in place of the live bus.
    assign have_resp = dc_rvalid_i || resp_pend_reg;
    assign resp_word = dc_rvalid_i ? dc_rdata_i : resp_data_reg;

    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        assign byte_lane[gi] = resp_word[8*gi +: 8];
    end

    assign sel_byte = byte_lane[ld_off_reg];
    assign sel_half = ld_off_reg[1] ? resp_word[31:16] : resp_word[15:0];

    // Extend the selected lane according to the captured load flavour.
    always_comb begin
        load_data = resp_word;
        case (ld_op_reg)
            ALU_LDB:  load_data = {{24{sel_byte[7]}}, sel_byte};
            ALU_LDBU: load_data = {24'h0, sel_byte};
            ALU_LDH:  load_data = {{16{sel_half[15]}}, sel_half};
            ALU_LDHU: load_data = {16'h0, sel_half};
            default:  load_data = resp_word;
        endcase
    end

`ifdef MEM_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] tmo_cnt_reg;

    // Count cycles spent waiting on the dcache; saturate at the limit.
    always_ff @(posedge clk) begin
        if (rst || state_reg == IDLE) begin
            tmo_cnt_reg <= '0;
        end else if (tmo_cnt_reg != CNT_W'(TIMEOUT_CYCLES - 1)) begin
            tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
        end
    end

    assign timeout_hit = (state_reg != IDLE) && (tmo_cnt_reg == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
    assign timeout_hit = 1'b0;
`endif

    // Pipeline register plus load-wait state machine.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg        <= IDLE;
            wb_valid_reg     <= 1'b0;
            wb_pc_reg        <= '0;
            wb_reg_we_reg    <= 1'b0;
            wb_reg_waddr_reg <= '0;
            wb_reg_wdata_reg <= '0;
            wb_err_reg       <= 1'b0;
            ld_op_reg        <= '0;
            ld_off_reg       <= '0;
            ld_we_reg        <= 1'b0;
            resp_pend_reg    <= 1'b0;
            resp_data_reg    <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (flush) begin
                        wb_valid_reg  <= 1'b0;
                        wb_reg_we_reg <= 1'b0;
                        wb_err_reg    <= 1'b0;
                    end else if (!pause_i) begin
                        wb_err_reg       <= 1'b0;
                        wb_pc_reg        <= ex_pc_i;
                        wb_reg_waddr_reg <= ex_reg_waddr_i;
                        if (ex_valid_i && ex_is_load && ex_mem_req_i) begin
                            wb_valid_reg  <= 1'b0;
                            wb_reg_we_reg <= 1'b0;
                            ld_op_reg     <= ex_aluop_i;
                            ld_off_reg    <= ex_addr_i[1:0];
                            ld_we_reg     <= ex_reg_we_i;
                            resp_pend_reg <= 1'b0;
                            state_reg     <= WAIT;
                        end else begin
                            wb_valid_reg     <= ex_valid_i;
                            wb_reg_we_reg    <= ex_valid_i && ex_reg_we_i;
                            wb_reg_wdata_reg <= ex_reg_wdata_i;
                        end
                    end
                end
                WAIT: begin
                    if (flush) begin
                        wb_valid_reg  <= 1'b0;
                        wb_reg_we_reg <= 1'b0;
                        wb_err_reg    <= 1'b0;
                        resp_pend_reg <= 1'b0;
                        state_reg     <= (have_resp || timeout_hit) ? IDLE : DRAIN;
                    end else if (pause_i) begin
                        if (dc_rvalid_i) begin
                            resp_pend_reg <= 1'b1;
                            resp_data_reg <= dc_rdata_i;
                        end
                    end else if (have_resp) begin
                        wb_valid_reg     <= 1'b1;
                        wb_reg_we_reg    <= ld_we_reg;
                        wb_reg_wdata_reg <= load_data;
                        wb_err_reg       <= 1'b0;
                        resp_pend_reg    <= 1'b0;
                        state_reg        <= IDLE;
                    end else if (timeout_hit) begin
                        wb_valid_reg     <= 1'b1;
                        wb_reg_we_reg    <= ld_we_reg;
                        wb_reg_wdata_reg <= '0;
                        wb_err_reg       <= 1'b1;
                        state_reg        <= IDLE;
                    end else begin
                        wb_valid_reg  <= 1'b0;
                        wb_reg_we_reg <= 1'b0;
                        wb_err_reg    <= 1'b0;
                    end
                end
                DRAIN: begin
                    if (dc_rvalid_i || timeout_hit) begin
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign pause_mem_o    = (state_reg != IDLE);
    assign wb_valid_o     = wb_valid_reg;
    assign wb_pc_o        = wb_pc_reg;
    assign wb_reg_we_o    = wb_reg_we_reg;
    assign wb_reg_waddr_o = wb_reg_waddr_reg;
    assign wb_reg_wdata_o = wb_reg_wdata_reg;
    assign wb_err_o       = wb_err_reg;

endmodule
